// File: rtl/sdram_fetch_pkg.sv
// Shared types and constants for the SDRAM scanout fetch path.
package sdram_fetch_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DATA = 2'd3
    } fetch_state_e;

    // Bits needed to hold a word count running from 0 up to and including total.
    function automatic int word_cnt_width(input int total);
        return $clog2(total + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead FIFO: the head entry is visible on rd_data while not empty.
// flush empties the FIFO synchronously and takes priority over reads/writes.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_V = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             wr_ok;
    logic             rd_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_V);
    assign rd_ok   = rd_en && !empty;
    // A write into a full FIFO is allowed when a pop frees the slot on the same edge.
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign count   = count_reg;
    // Empty FIFO presents zero rather than stale storage.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(wr_ok) - CW'(rd_ok);
        end
    end

endmodule

// File: rtl/sdram_line_fetcher.sv
// Framebuffer scanout: single-word SDRAM reads into a show-ahead pixel FIFO.
// One read in flight at most; each in-flight read reserves a FIFO slot.
module sdram_line_fetcher
    import sdram_fetch_pkg::*;
#(
    parameter int                FIFO_DEPTH = 16,
    parameter int                LINE_WORDS = 800,
    parameter int                LINES      = 480,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 22'h000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pix_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              frame_done,
    output logic              underrun,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_enable,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              busy
);

    localparam int TOTAL = LINE_WORDS * LINES;
    localparam int CNT_W = word_cnt_width(TOTAL);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = FCW + 1;
    localparam logic [CNT_W-1:0] TOTAL_V = CNT_W'(TOTAL);
    localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(FIFO_DEPTH);

    fetch_state_e     state_reg;
    fetch_state_e     state_next;
    logic [CNT_W-1:0] word_cnt_reg;
    logic             frame_active_reg;
    logic             frame_done_reg;
    logic             underrun_reg;
    logic             discard_reg;

    logic [FCW-1:0]   fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             capture;
    logic             push;
    logic             pop;
    logic             in_flight;
    logic [OCC_W-1:0] occupancy;
    logic             slot_free;
    logic [CNT_W-1:0] cnt_after;
    logic             issue_ok;
    logic             all_fetched;

    // Returning word is on rd_data this cycle.
    assign capture     = (state_reg == ST_WAIT_DATA) && !busy;
    // frame_start beats both the returning word and any pop on the same edge.
    assign push        = capture && !discard_reg && !frame_start;
    assign pop         = pix_ready && !fifo_empty && !frame_start;
    // A discarded read has no claim on a FIFO slot.
    assign in_flight   = (state_reg != ST_IDLE) && !discard_reg;
    assign occupancy   = OCC_W'(fifo_count) + OCC_W'(in_flight);
    // Occupancy seen here already includes the read being captured now.
    assign slot_free   = (!fifo_full && (occupancy < DEPTH_V)) || pop;
    assign cnt_after   = word_cnt_reg + CNT_W'(push);
    assign issue_ok    = frame_active_reg && (cnt_after < TOTAL_V) && slot_free;
    assign all_fetched = (word_cnt_reg == TOTAL_V);

    assign rd_addr     = BASE_ADDR + ADDR_W'(word_cnt_reg);
    assign pix_valid   = !fifo_empty;
    assign frame_done  = frame_done_reg;
    assign underrun    = underrun_reg;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (frame_start),
        .wr_en   (push),
        .wr_data (rd_data),
        .rd_en   (pop),
        .rd_data (pix_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Read-request sequencing; an unaccepted request is dropped by frame_start.
    always_comb begin
        state_next = state_reg;
        rd_enable  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!frame_start && issue_ok) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rd_enable = !frame_start;
                if (frame_start) begin
                    state_next = ST_IDLE;
                end else if (!busy) begin
                    state_next = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (busy) begin
                    state_next = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (!busy) begin
                    state_next = (!frame_start && issue_ok) ? ST_ISSUE : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, word counter and frame status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            word_cnt_reg     <= '0;
            frame_active_reg <= 1'b0;
            frame_done_reg   <= 1'b0;
            underrun_reg     <= 1'b0;
            discard_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (frame_start) begin
                word_cnt_reg     <= '0;
                frame_active_reg <= 1'b1;
                frame_done_reg   <= 1'b0;
                underrun_reg     <= 1'b0;
                // A read already accepted by the controller still returns; drop its word.
                discard_reg      <= (state_reg == ST_WAIT_BUSY) ||
                                    ((state_reg == ST_WAIT_DATA) && busy);
            end else begin
                if (push) begin
                    word_cnt_reg <= word_cnt_reg + CNT_W'(1);
                end
                if (capture) begin
                    discard_reg <= 1'b0;
                end
                if (frame_active_reg && all_fetched && fifo_empty) begin
                    frame_done_reg <= 1'b1;
                end
                if (frame_active_reg && !frame_done_reg && !(all_fetched && fifo_empty) &&
                    pix_ready && fifo_empty) begin
                    underrun_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/sdram_line_fetcher.md
# sdram_line_fetcher

Read-side scanout engine between `sdram_controller` and the LVDS display pipeline. Walks a framebuffer region in SDRAM word by word, issues single-word reads through the controller host port, and buffers returned pixels in a small show-ahead FIFO. The display timing logic pops pixels. Keeps the FIFO topped up so that pixel delivery is decoupled from SDRAM refresh and write traffic.

## Interface
- `FIFO_DEPTH`, 16: pixel FIFO entries; power of two, ≥4.
- `LINE_WORDS`, 800: 16-bit pixels per line.
- `LINES`, 480: lines per frame.
- `BASE_ADDR`, 22'h000000: SDRAM word address of pixel (0,0).
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle pulse; flush and restart the fetch at `BASE_ADDR`.
- `pix_ready`  in  1  consumer pops head pixel when `pix_valid` is high.
- `pix_data`  out  16  head-of-FIFO pixel; valid while `pix_valid`.
- `pix_valid`  out  1  FIFO non-empty.
- `frame_done`  out  1  all `LINE_WORDS*LINES` words fetched and FIFO drained; sticky until `frame_start`.
- `underrun`  out  1  sticky; `pix_ready` seen with `pix_valid` low while the frame is active.
- `rd_addr`  out  22  to controller `rd_addr`.
- `rd_enable`  out  1  to controller `rd_enable`.
- `rd_data`  in  16  from controller `rd_data`.
- `busy`  in  1  from controller `busy`.

## Operation
- Controller contract: a read is accepted on the cycle `rd_enable`=1 and `busy`=0. `busy` rises the next cycle. `rd_data` is valid on the first cycle `busy` is low again.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DATA.
- IDLE -> ISSUE: the frame is active, the word count is below `LINE_WORDS*LINES`, and the FIFO has a free slot, counting one slot reserved per in-flight read.
- ISSUE: drive `rd_enable`=1 and `rd_addr`=current address. Hold both until `busy`=0 is sampled with `rd_enable` high, then go to WAIT_BUSY.
- WAIT_BUSY: `rd_enable`=0. Go to WAIT_DATA when `busy`=1.
- WAIT_DATA: when `busy`=0, write `rd_data` into the FIFO, increment address and word count, then go to ISSUE if the ISSUE condition still holds, otherwise IDLE.
- Address arithmetic: 22-bit, `BASE_ADDR + word_count`, modulo 2^22.
- Word count: ceil(log2(LINE_WORDS*LINES+1)) bits. At the last word the FSM stays in IDLE until `frame_start`. There is no automatic wrap.
- `frame_start` in IDLE or ISSUE:
  - flush the FIFO, zero the count, clear `frame_done` and `underrun`;
  - drop any unaccepted `rd_enable`; return to IDLE.
- `frame_start` in WAIT_BUSY/WAIT_DATA:
  - flush and clear immediately;
  - set a discard flag so the returning word is not written;
  - then restart from `BASE_ADDR`. A read is never abandoned on the controller side.
- Simultaneous FIFO push and pop: both take effect and occupancy is unchanged.
- A pop on an empty FIFO is ignored and sets `underrun` if the frame is active and not done.
- `frame_start` coincident with a pop: `frame_start` wins and the pop is discarded.

## Timing
- Reset values:
  - `rd_enable`=0, `rd_addr`=`BASE_ADDR`;
  - `pix_valid`=0, `pix_data`=0;
  - `frame_done`=0, `underrun`=0;
  - FSM in IDLE, frame inactive.
- `frame_start` sampled at edge N: FSM is in ISSUE with `rd_enable`=1 at edge N+1.
- Pixel appears on `pix_valid` the cycle after the WAIT_DATA capture edge, giving a registered FIFO write.
- Show-ahead FIFO: `pix_data` updates the cycle after a pop edge. No bubble while occupancy is ≥2.
- Throughput: at most one read in flight, so one word per controller read cycle (accept + `busy` period + 1).
- `frame_done` rises on the edge after the last pixel is popped.

## Structure
- Package `sdram_fetch_pkg`:
  - FSM state enum;
  - `ADDR_W`=22 and `DATA_W`=16 constants;
  - a function computing the word-count width.
- Sub-module `sync_fifo`: show-ahead, parameterised depth/width, synchronous flush input, `full`/`empty`/`count` outputs. The top holds the FSM, counters, reservation logic and flags.

## Test plan
Bench parameters: `LINE_WORDS`=4, `LINES`=2, `BASE_ADDR`=22'h000100, `FIFO_DEPTH`=4. The controller model holds `busy` high for 6 cycles and returns `rd_data` = `rd_addr[15:0]`.
- Reset then `frame_start` with `pix_ready`=1 -> pixels 16'h0100..16'h0107 in order, then `frame_done`=1, no `underrun`.
- `pix_ready`=0 after `frame_start` -> exactly 4 reads issued, FIFO full, `rd_enable` stays 0. One pop -> exactly one further read at 22'h000104.
- Model holds `busy`=1 for 10 cycles before accepting -> `rd_enable` and `rd_addr` held stable throughout, single acceptance.
- `frame_start` pulsed in WAIT_DATA of the 3rd read -> that word (16'h0102) is never output. Next output is 16'h0100, FIFO flushed.
- `pix_ready`=1 continuously with slow model -> `underrun` rises on the first empty pop, stays high, and clears on `frame_start`.
- `rst_n` asserted mid-read -> all outputs at reset values immediately; after release, no `rd_enable` until `frame_start`.
